// File: rtl/uart_tx_fifo_drain_if.sv
// Read-port bundle between a show-ahead FIFO and the UART transmitter that
// drains it.
//   i_fifo_data  : FIFO head word, valid in the cycle the pop strobe is high
//   i_fifo_empty : FIFO empty flag (registered inside the FIFO)
//   o_fifo_rd_en : single-cycle pop strobe issued by the transmitter
// master = transmitter side (issues pops), slave = FIFO side.
interface uart_tx_fifo_drain_if #(
  parameter int DataBits = 8
);
  logic [DataBits-1:0] i_fifo_data;
  logic                i_fifo_empty;
  logic                o_fifo_rd_en;

  modport master (
    input  i_fifo_data,
    input  i_fifo_empty,
    output o_fifo_rd_en
  );

  modport slave (
    output i_fifo_data,
    output i_fifo_empty,
    input  o_fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a show-ahead FIFO read port. One word is
// popped whenever the block is idle, enabled and the FIFO is non-empty; the
// word is sent LSB first as start bit, data bits, optional parity, stop bits.
// Ports:
//   i_clk      : clock (FIFO read clock)
//   i_rst      : synchronous reset, active-high
//   i_enable   : permits starting new frames (sampled only while idle)
//   fifo       : FIFO read port (data, empty in; pop strobe out)
//   o_tx       : registered serial line, idles high
//   o_busy     : high for every cycle a frame is on the line
module uart_tx_fifo_drain #(
  parameter int ClkDiv    = 16,
  parameter int DataBits  = 8,
  parameter int ParityEn  = 0,
  parameter int ParityOdd = 0,
  parameter int StopBits  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  uart_tx_fifo_drain_if.master        fifo,
  output logic                        o_tx,
  output logic                        o_busy
);

  localparam int BAUD_W  = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
  localparam int BIT_MAX = (DataBits > StopBits) ? DataBits : StopBits;
  localparam int BIT_W   = (BIT_MAX > 2) ? $clog2(BIT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(ClkDiv - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DataBits - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(StopBits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                holdoff_q, holdoff_d;

  logic                pop;
  logic                baud_end;
  logic [DataBits-1:0] shift_nx;

  // Holdoff keeps the first post-reset cycle pop-free so the FIFO's
  // registered empty flag has settled before it is trusted.
  assign pop      = (state_q == S_IDLE) & i_enable & ~fifo.i_fifo_empty & ~holdoff_q;
  assign baud_end = (baud_q == BAUD_LAST);
  assign shift_nx = shift_q >> 1;

  assign fifo.o_fifo_rd_en = pop;
  assign o_tx              = tx_q;
  assign o_busy            = busy_q;

  // tx_d always carries the line level of the bit the next state starts,
  // so o_tx comes straight from a flop and changes exactly on bit edges.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    holdoff_d = 1'b0;

    if (state_q == S_IDLE) begin
      if (pop) begin
        state_d = S_START;
        shift_d = fifo.i_fifo_data;
        par_d   = (^fifo.i_fifo_data) ^ (ParityOdd != 0);
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (!baud_end) begin
      baud_d = baud_q + 1'b1;
    end else begin
      baud_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
        S_DATA: begin
          shift_d = shift_nx;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (ParityEn != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_nx[0];
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
        S_STOP: begin
          tx_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      holdoff_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      holdoff_q <= holdoff_d;
    end
  end

  // Payload registers carry no reset; they are only read after a pop loads them.
  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
UART transmitter that sits directly downstream of the read port of the team's clock-domain-crossing FIFO, in the read clock domain. It pops one word from the FIFO when the FIFO is non-empty and serializes it LSB-first as an 8N1-style frame. The frame format is set at elaboration time.

Parameters:
ClkDiv, 16, clocks per UART bit; legal range is 2 or more.
DataBits, 8, data bits per frame; must equal the FIFO Width.
ParityEn, 0, 1 adds a parity bit after the data bits.
ParityOdd, 0, selects parity sense when ParityEn=1: 0 = even, 1 = odd.
StopBits, 1, number of stop bits; legal values are 1 or 2.

Ports:
i_clk  input  1  clock; same clock as the FIFO read clock.
i_rst  input  1  synchronous reset, active-high.
i_enable  input  1  permits starting new frames.
i_fifo_data  input  DataBits  FIFO read data; valid in the same cycle as the pop (show-ahead).
i_fifo_empty  input  1  FIFO empty flag; registered in the FIFO.
o_fifo_rd_en  output  1  single-cycle pop strobe to the FIFO.
o_tx  output  1  serial line; idles high.
o_busy  output  1  high while a frame is on the line.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - Next cycle: state=IDLE, o_tx=1, o_busy=0, o_fifo_rd_en=0, all counters 0, holdoff flag set.
  - Reset mid-frame aborts the frame immediately; the partially sent byte is lost.
- Holdoff: no pop occurs in the first cycle after reset deasserts, which lets the FIFO empty flag settle.
- FSM states:
  - IDLE -> START when i_enable=1, i_fifo_empty=0 and holdoff is clear.
  - START -> DATA.
  - DATA -> PARITY if ParityEn=1, otherwise -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Pop:
  - o_fifo_rd_en is combinational: (state==IDLE) & i_enable & ~i_fifo_empty & ~holdoff.
  - On that same edge, i_fifo_data is captured into the shift register and the parity accumulator.
  - o_fifo_rd_en is never high in two consecutive cycles.
  - i_fifo_empty is ignored outside IDLE. The minimum spacing between pops is longer than the FIFO's one-cycle flag lag.
- Bit timing:
  - Baud counter runs 0..ClkDiv-1; each bit lasts exactly ClkDiv cycles.
  - Bit counter runs 0..DataBits-1 in DATA and 0..StopBits-1 in STOP.
- Latency: pop at edge N; o_tx=0 (start bit) from cycle N+1.
- Line sequence: start bit (0), data LSB first, optional parity bit, stop bits (1).
- Parity bit value is XOR(data) ^ ParityOdd.
- Frame length F = ClkDiv*(1+DataBits+ParityEn+StopBits) cycles.
- o_busy is 1 for exactly those F cycles.
- Back-to-back frames:
  - After the last stop-bit cycle the block is in IDLE for one cycle, with o_tx=1.
  - A pop can occur in that IDLE cycle, so consecutive pops are exactly F+1 cycles apart.
- i_enable:
  - Dropping i_enable mid-frame does not affect the current frame; the frame completes and no further pop occurs.
  - i_enable is sampled only in IDLE.
- o_tx is registered (driven from a flop), so there are no glitches.
- Counter widths are $clog2 of their range, with a minimum of 1 bit. Counters wrap only via explicit compare; they never rely on natural overflow.

Test Plan:
1. Single byte (ClkDiv=4, DataBits=8, no parity, StopBits=1).
   - Stimulus: FIFO holds 0xA5.
   - Response: one pop; o_tx shows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; o_busy high for 40 cycles; o_fifo_rd_en high for exactly 1 cycle.
2. Back-to-back (same configuration).
   - Stimulus: FIFO holds 0x00, 0xFF, 0x3C.
   - Response: pops 41 cycles apart; o_tx is high for exactly 1 cycle between frames; decoded bytes match and are in order.
3. Parity (ParityEn=1).
   - Stimulus: 0x07 with ParityOdd=0.
   - Response: parity bit 1, frame 44 cycles.
   - Stimulus: 0x07 with ParityOdd=1.
   - Response: parity bit 0.
4. Empty and enable gating.
   - Stimulus: i_fifo_empty held high.
   - Response: no pop; o_tx stays 1.
   - Stimulus: i_enable drops in the middle of frame 1 of 2.
   - Response: frame 1 completes; no second pop until i_enable returns high.
5. Reset mid-frame.
   - Stimulus: assert i_rst during data bit 3.
   - Response: next cycle o_tx=1 and o_busy=0; after release there is no pop in the first cycle, and the next byte frame starts cleanly.
6. StopBits=2, ClkDiv=2.
   - Stimulus: one 0x81 byte.
   - Response: frame 22 cycles; final 4 cycles high.
